// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO access controller.
// Sequences one SRAM or device-register access per MIO_EN request and returns
// the one-cycle R (memory ready) pulse. Also owns KBSR/KBDR/DSR/DDR and the
// registered keyboard interrupt line.
module lc3_mem_ctrl #(
    parameter int WAIT_STATES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    output logic        R,
    output logic [15:0] MEM_DATA,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack,
    output logic        INT
);

    typedef enum logic [1:0] {IDLE, ACCESS, READY, DONE} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    // Device register select, taken from MAR[2:1] within xFE00..xFE06
    localparam logic [1:0] SEL_KBSR = 2'd0;
    localparam logic [1:0] SEL_KBDR = 2'd1;
    localparam logic [1:0] SEL_DSR  = 2'd2;
    localparam logic [1:0] SEL_DDR  = 2'd3;

    state_t      state, state_nx;
    logic [15:0] addr_q, wdata_q;
    logic        rw_q, is_dev_q;
    logic [1:0]  sel_q;
    logic [3:0]  cnt_q;

    logic        kb_rdy, kb_ie, ds_rdy, ds_ie;
    logic [7:0]  kbdr;

    logic        dev_hit;
    logic        last_acc, commit;
    logic        wr_kbsr, wr_dsr, wr_ddr, rd_kbdr;
    logic [15:0] dev_rdata;

    // Only the four even addresses xFE00..xFE06 are devices; the rest of xFExx is SRAM
    assign dev_hit = (MAR[15:3] == 13'h1FC0) && !MAR[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; devices take a single ACCESS cycle, SRAM takes WAIT_STATES+1
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (MIO_EN) state_nx = ACCESS;
            ACCESS:  if (is_dev_q || cnt_q == WS) state_nx = READY;
            READY:   state_nx = DONE;
            DONE:    if (!MIO_EN) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign last_acc = (state == ACCESS) && (state_nx == READY);
    assign commit   = (state == READY);

    assign wr_kbsr = commit && is_dev_q &&  rw_q && (sel_q == SEL_KBSR);
    assign wr_dsr  = commit && is_dev_q &&  rw_q && (sel_q == SEL_DSR);
    assign wr_ddr  = commit && is_dev_q &&  rw_q && (sel_q == SEL_DDR);
    assign rd_kbdr = commit && is_dev_q && !rw_q && (sel_q == SEL_KBDR);

    // Read mux for device registers; unimplemented status bits read as 0
    always_comb begin
        dev_rdata = 16'h0000;
        case (sel_q)
            SEL_KBSR: dev_rdata = {kb_rdy, kb_ie, 14'h0};
            SEL_KBDR: dev_rdata = {8'h00, kbdr};
            SEL_DSR:  dev_rdata = {ds_rdy, ds_ie, 14'h0};
            SEL_DDR:  dev_rdata = {8'h00, disp_data};
            default:  dev_rdata = 16'h0000;
        endcase
    end

    // SRAM strobes are held for the whole ACCESS window and never asserted for devices
    assign mem_en    = (state == ACCESS) && !is_dev_q;
    assign mem_we    = mem_en && rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Request latch, wait-state counter, read-data capture and ready pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rw_q     <= 1'b0;
            is_dev_q <= 1'b0;
            sel_q    <= 2'd0;
            cnt_q    <= 4'd0;
            MEM_DATA <= 16'h0000;
            R        <= 1'b0;
        end else begin
            R <= commit;
            if (state == IDLE && MIO_EN) begin
                addr_q   <= MAR;
                wdata_q  <= MDR_in;
                rw_q     <= R_W;
                is_dev_q <= dev_hit;
                sel_q    <= MAR[2:1];
                cnt_q    <= 4'd0;
            end else if (state == ACCESS) begin
                cnt_q <= cnt_q + 4'd1;
            end
            // Captured before the READY-edge side effects, so a KBDR read sees the old key
            if (last_acc && !rw_q)
                MEM_DATA <= is_dev_q ? dev_rdata : mem_rdata;
        end
    end

    // Keyboard registers: a new key wins over the clear from a coincident KBDR read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_rdy <= 1'b0;
            kb_ie  <= 1'b0;
            kbdr   <= 8'h00;
            INT    <= 1'b0;
        end else begin
            if (kbd_valid)    kb_rdy <= 1'b1;
            else if (rd_kbdr) kb_rdy <= 1'b0;
            if (kbd_valid)    kbdr   <= kbd_data;
            if (wr_kbsr)      kb_ie  <= wdata_q[14];
            INT <= kb_rdy && kb_ie;
        end
    end

    // Display registers: a DDR write wins over a coincident disp_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_rdy     <= 1'b1;
            ds_ie      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            disp_valid <= wr_ddr;
            if (wr_ddr)        ds_rdy <= 1'b0;
            else if (disp_ack) ds_rdy <= 1'b1;
            if (wr_dsr)        ds_ie  <= wdata_q[14];
            if (wr_ddr)        disp_data <= wdata_q[7:0];
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: read results are queued when a request is
// issued and checked when R pulses; timing, strobe counts and device side
// effects are checked inline.
module tb_lc3_mem_ctrl;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MIO_EN = 1'b0, R_W = 1'b0;
    logic [15:0] MAR = 16'h0, MDR_in = 16'h0;
    logic        R;
    logic [15:0] MEM_DATA, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ack = 1'b0;
    logic        INT;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
        .MDR_in(MDR_in), .R(R), .MEM_DATA(MEM_DATA), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack),
        .INT(INT)
    );

    // SRAM model: 16 words selected by the top address nibble; x3000 preloaded with x1234
    bit [15:0] sram [16];
    bit [15:0] wflag;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            sram[mem_addr[15:12]]  <= mem_wdata;
            wflag[mem_addr[15:12]] <= 1'b1;
        end
    end
    assign mem_rdata = wflag[mem_addr[15:12]] ? sram[mem_addr[15:12]] :
                       (mem_addr[15:12] == 4'h3) ? 16'h1234 : 16'hA5A5;

    typedef struct {
        bit          chk;
        logic [15:0] d;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int vectors = 0, miscompares = 0;
    int en_cnt = 0, we_cnt = 0, dv_cnt = 0;
    logic [7:0] dv_data = 8'h00;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge, track strobes and retire scoreboard entries on R
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
            if (disp_valid) begin dv_cnt++; dv_data = disp_data; end
            if (R) begin
                if (sb.size() == 0) check("spurious_R", {15'h0, R}, 16'h0);
                else begin
                    e = sb.pop_front();
                    if (e.chk) check(e.tag, MEM_DATA, e.d);
                end
            end
        end
    endtask

    // Issue one access, check the R latency, then hold MIO_EN for 'hold' extra cycles
    task automatic access(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] exp, input bit chk, input string tag,
                          input int hold, input bit drop_early, input int kbd_at,
                          input logic [7:0] kcode);
        int lat, exp_lat;
        exp_lat = ((addr & 16'hFFF9) == 16'hFE00) ? 3 : WS + 3;
        sb.push_back('{chk, exp, tag});
        MIO_EN = 1'b1; R_W = rw; MAR = addr; MDR_in = data;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            step();
            if (drop_early && i == 1) MIO_EN = 1'b0;
            kbd_valid = (i == kbd_at);
            if (i == kbd_at) kbd_data = kcode;
            if (R) lat = i;
        end
        kbd_valid = 1'b0;
        check({"lat_", tag}, 16'(lat), 16'(exp_lat));
        repeat (hold) step();
        MIO_EN = 1'b0;
        repeat (7) step();
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        access(1'b0, addr, 16'h0, exp, 1'b1, tag, 0, 1'b0, 0, 8'h00);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string tag);
        access(1'b1, addr, data, 16'h0, 1'b0, tag, 0, 1'b0, 0, 8'h00);
    endtask

    initial begin
        int e0, w0, d0;
        // reset values
        step(); step();
        check("rst_ctrl", {11'h0, R, mem_en, mem_we, disp_valid, INT}, 16'h0);
        check("rst_mem_data", MEM_DATA, 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_disp_data", {8'h0, disp_data}, 16'h0);
        rst_n = 1'b1;
        step();
        rd(16'hFE00, 16'h0000, "rst_kbsr");
        rd(16'hFE04, 16'h8000, "rst_dsr");
        rd(16'hFE02, 16'h0000, "rst_kbdr");

        // SRAM read with wait states
        e0 = en_cnt; w0 = we_cnt;
        rd(16'h3000, 16'h1234, "sram_rd");
        check("sram_rd_en_cycles", 16'(en_cnt - e0), 16'd4);
        check("sram_rd_we_cycles", 16'(we_cnt - w0), 16'd0);

        // SRAM write with MIO_EN held after R: exactly one access
        e0 = en_cnt; w0 = we_cnt;
        access(1'b1, 16'h4000, 16'hBEEF, 16'h0, 1'b0, "sram_wr", 3, 1'b0, 0, 8'h00);
        check("sram_wr_en_cycles", 16'(en_cnt - e0), 16'd4);
        check("sram_wr_we_cycles", 16'(we_cnt - w0), 16'd4);
        rd(16'h4000, 16'hBEEF, "sram_rdback");

        // MIO_EN dropped during ACCESS still completes
        access(1'b0, 16'h3000, 16'h0, 16'h1234, 1'b1, "sram_drop", 0, 1'b1, 0, 8'h00);

        // xFE08 is not a device: goes to SRAM
        e0 = en_cnt;
        rd(16'hFE08, 16'hA5A5, "fe08_sram");
        check("fe08_en_cycles", 16'(en_cnt - e0), 16'd4);

        // keyboard: key, enable, INT, read clears
        kbd_valid = 1'b1; kbd_data = 8'h41; step(); kbd_valid = 1'b0; step(); step();
        check("int_no_ie", {15'h0, INT}, 16'h0);
        e0 = en_cnt;
        wr(16'hFE00, 16'h4000, "kbsr_wr");
        check("dev_no_sram", 16'(en_cnt - e0), 16'd0);
        check("int_rise", {15'h0, INT}, 16'h1);
        rd(16'hFE00, 16'hC000, "kbsr_rdy_ie");
        rd(16'hFE02, 16'h0041, "kbdr_rd");
        check("int_fall", {15'h0, INT}, 16'h0);
        rd(16'hFE00, 16'h4000, "kbsr_cleared");

        // display: DDR write pulses disp_valid, clears DSR ready until ack
        d0 = dv_cnt;
        wr(16'hFE06, 16'h0058, "ddr_wr");
        check("disp_valid_pulses", 16'(dv_cnt - d0), 16'd1);
        check("disp_data", {8'h0, dv_data}, 16'h0058);
        rd(16'hFE04, 16'h0000, "dsr_busy");
        disp_ack = 1'b1; step(); disp_ack = 1'b0; step();
        rd(16'hFE04, 16'h8000, "dsr_acked");

        // new key coincident with KBDR read commit: old data returned, ready stays set
        access(1'b0, 16'hFE02, 16'h0, 16'h0041, 1'b1, "kbdr_collide", 0, 1'b0, 2, 8'h42);
        check("int_after_collide", {15'h0, INT}, 16'h1);
        rd(16'hFE00, 16'hC000, "kbsr_collide");
        rd(16'hFE02, 16'h0042, "kbdr_new");

        // reset in the middle of an SRAM write
        wr(16'hFE06, 16'h0033, "ddr_wr2");
        wr(16'hFE04, 16'h4000, "dsr_ie_wr");
        rd(16'hFE04, 16'h4000, "dsr_ie");
        kbd_valid = 1'b1; kbd_data = 8'h55; step(); kbd_valid = 1'b0; step();
        MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'h5000; MDR_in = 16'h1111;
        step(); step();
        check("pre_rst_strobes", {14'h0, mem_en, mem_we}, 16'h3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {13'h0, R, mem_en, mem_we}, 16'h0);
        MIO_EN = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step(); step(); step(); step();
        check("rst_mid_int", {15'h0, INT}, 16'h0);
        rd(16'hFE04, 16'h8000, "rst_mid_dsr");
        rd(16'hFE00, 16'h0000, "rst_mid_kbsr");

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
